matrix_loader: RTL and testbench
================================

Name: matrix_loader

Overview:
Matrix weight store and fetch responder that serves `matvec_multiplier`'s matrix read interface.
- It holds the row-major matrix in an internal single-read-port word memory, loaded by the host one word per cycle.
- On a `matrix_enable` request it gathers BANDWIDTH consecutive words starting at `matrix_addr` into a wide beat, then pulses `matrix_ready`.
- The beat stays stable on `matrix_data` until the next fetch begins, covering the multiplier's multi-cycle MAC phase.

Parameters:
- MAX_ROWS, 64, maximum matrix rows.
- MAX_COLS, 64, maximum matrix columns.
- BANDWIDTH, 16, words per fetch beat.
- DATA_WIDTH, 16, bits per word (signed Q-format; treated as opaque bits here).
- DEPTH (local), MAX_ROWS*MAX_COLS, number of memory words.
- ADDR_WIDTH (local), $clog2(DEPTH).

Ports:
- clk, input, 1, clock; all logic on posedge.
- rst, input, 1, synchronous active-high reset.
- mem_write_enable, input, 1, host word write strobe.
- mem_write_addr, input, ADDR_WIDTH, host word address.
- mem_write_data, input, DATA_WIDTH, host write data.
- matrix_addr, input, ADDR_WIDTH, base word address of the requested beat.
- matrix_enable, input, 1, fetch request from the multiplier.
- matrix_data, output, DATA_WIDTH*BANDWIDTH, fetched beat; lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- matrix_ready, output, 1, one-cycle pulse: beat complete.
- busy, output, 1, high in any state except IDLE.

Behaviour:
- Reset, sampled on posedge when rst=1: state=IDLE, matrix_data=0, matrix_ready=0, busy=0, internal counters=0.
  - Memory contents are not cleared.
  - Reset mid-fetch aborts the fetch; no ready pulse follows.
  - Reset takes priority over all other inputs.
- FSM, one-hot: IDLE, FETCH, DONE, HOLD.
- IDLE:
  - If matrix_enable=1: latch base=matrix_addr, rd_idx=0, go to FETCH.
  - Else stay.
- FETCH:
  - Each cycle issue one read of word base+rd_idx.
  - The registered result is written into lane rd_idx of matrix_data.
  - rd_idx increments each cycle.
  - After the read with rd_idx=BANDWIDTH-1, go to DONE.
  - matrix_addr and matrix_enable are ignored during FETCH; the base is the latched value.
- DONE: matrix_ready=1 for exactly this cycle.
  - If matrix_enable=1, go to HOLD.
  - Else go to IDLE.
- HOLD: wait for matrix_enable=0, then go to IDLE.
  - This guarantees an enable still high during the ready cycle never triggers a duplicate fetch.
  - A new request needs enable low for at least one cycle.
- Latency: enable sampled in IDLE at cycle T gives matrix_ready=1 in cycle T+BANDWIDTH+1 (17 cycles at default).
- Boundaries and data rules:
  - Word addresses base+i >= DEPTH return 0 in that lane. There is no wrap-around; the compare is done at ADDR_WIDTH+1 bits.
  - During FETCH, lanes not yet refreshed keep their previous values. Consumers may sample only after matrix_ready.
  - After DONE, matrix_data is unchanged until the next FETCH starts.
- Write port:
  - Accepted in every state, one word per cycle, into mem[mem_write_addr]; takes effect the following cycle.
  - Simultaneous read and write of the same address is read-first: the fetch gets the old word.
  - Writes with mem_write_addr >= DEPTH are dropped.
- Memory is a single read port plus a single write port, inferable as block RAM. matrix_data and matrix_ready are registered outputs.

Test Plan:
- Load mem[k]=k+1 for k=0..4095; request base 0 with enable held until ready -> ready exactly at T+17, lane i = i+1 for i=0..15, a single pulse, busy low after enable drops.
- Request base 4088 -> lanes 0..7 = 4089..4096, lanes 8..15 = 0.
- Hold enable high for 5 cycles after ready, then drop for 1 cycle, then raise with base 16 -> no refetch during the hold; second ready 17 cycles after the re-raise with lanes 17..32; matrix_data constant between the two fetches.
- Write mem[5]=0xBEEF in the exact cycle word 5 is read (base 0) -> lane 5 = 6 (old value); an immediate refetch returns lane 5 = 0xBEEF.
- Assert rst at fetch cycle 8, release, then request base 32 -> no ready from the aborted fetch; matrix_data=0 right after reset; new beat = 33..48 with a ready pulse 17 cycles after the request.
- Drive `matvec_multiplier` (4x16, num_cols=16) against this block with identity-like weights -> results equal the input vector and each row produces exactly one ready pulse.

Source files
------------

// File: rtl/matrix_loader.sv
// ---------------------------------------------------------------------------
// matrix_loader
// Matrix weight store plus fetch responder for the matvec multiplier.
// The host loads the row-major matrix one word per cycle. On a fetch request
// the block gathers BANDWIDTH consecutive words starting at matrix_addr into
// one wide beat. When the beat is complete it pulses matrix_ready for one
// cycle. The beat then stays on matrix_data until the next fetch starts.
//
// Ports
//   clk               clock, all logic on posedge
//   rst               synchronous active-high reset
//   mem_write_enable  host word write strobe
//   mem_write_addr    host word address
//   mem_write_data    host write data
//   matrix_addr       base word address of the requested beat
//   matrix_enable     fetch request from the multiplier
//   matrix_data       fetched beat, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   matrix_ready      one-cycle pulse: beat complete
//   busy              high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module matrix_loader #(
  parameter  int MAX_ROWS   = 64,
  parameter  int MAX_COLS   = 64,
  parameter  int BANDWIDTH  = 16,
  parameter  int DATA_WIDTH = 16,
  localparam int DEPTH      = MAX_ROWS * MAX_COLS,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            mem_write_enable,
  input  logic [ADDR_WIDTH-1:0]           mem_write_addr,
  input  logic [DATA_WIDTH-1:0]           mem_write_data,
  input  logic [ADDR_WIDTH-1:0]           matrix_addr,
  input  logic                            matrix_enable,
  output logic [DATA_WIDTH*BANDWIDTH-1:0] matrix_data,
  output logic                            matrix_ready,
  output logic                            busy
);

  localparam int LANE_W = (BANDWIDTH > 1) ? $clog2(BANDWIDTH) : 1;
  localparam int IDX_W  = LANE_W + 1;

  localparam logic [ADDR_WIDTH:0] DEPTH_X   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IDX_W-1:0]    BW_X      = IDX_W'(BANDWIDTH);
  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(BANDWIDTH - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_FETCH = 4'b0010,
    S_DONE  = 4'b0100,
    S_HOLD  = 4'b1000
  } state_t;

  state_t                          r_state;
  state_t                          w_state_next;

  logic [DATA_WIDTH-1:0]           r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]           r_base;
  logic [IDX_W-1:0]                r_rd_idx;
  logic [DATA_WIDTH-1:0]           r_rd_word;
  logic [LANE_W-1:0]               r_rd_lane;
  logic                            r_rd_oob;
  logic                            r_rd_vld;
  logic [DATA_WIDTH*BANDWIDTH-1:0] r_data;

  logic                            w_issue;
  logic [ADDR_WIDTH:0]             w_rd_addr;
  logic                            w_rd_oob;
  logic                            w_wr_ok;

  // One extra address bit so base+i past the end is seen as out of range
  // instead of wrapping back to the start of the memory.
  assign w_issue   = (r_state == S_FETCH) && (r_rd_idx < BW_X);
  assign w_rd_addr = {1'b0, r_base} + {{(ADDR_WIDTH + 1 - IDX_W){1'b0}}, r_rd_idx};
  assign w_rd_oob  = (w_rd_addr >= DEPTH_X);
  assign w_wr_ok   = mem_write_enable && ({1'b0, mem_write_addr} < DEPTH_X);

  // Word memory: one write port and one registered read port. The read and
  // the write sit in the same process with non-blocking updates, so a read
  // that collides with a write returns the old word (read-first).
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[mem_write_addr] <= mem_write_data;
    end
    if (w_issue) begin
      r_rd_word <= r_mem[w_rd_addr[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FETCH lasts until the last lane has come back through the read register.
  // That makes matrix_ready coincide with a fully written beat.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (matrix_enable) w_state_next = S_FETCH;
      S_FETCH: if (r_rd_vld && (r_rd_lane == LAST_LANE)) w_state_next = S_DONE;
      S_DONE:  w_state_next = matrix_enable ? S_HOLD : S_IDLE;
      S_HOLD:  if (!matrix_enable) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Read sequencing: latch the base when a request is accepted, then walk
  // rd_idx across the beat. The lane tag and the out-of-range flag travel
  // with each read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base    <= '0;
      r_rd_idx  <= '0;
      r_rd_lane <= '0;
      r_rd_oob  <= 1'b0;
      r_rd_vld  <= 1'b0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_rd_lane <= r_rd_idx[LANE_W-1:0];
        r_rd_oob  <= w_rd_oob;
        r_rd_idx  <= r_rd_idx + IDX_W'(1);
      end
      if ((r_state == S_IDLE) && matrix_enable) begin
        r_base   <= matrix_addr;
        r_rd_idx <= '0;
      end
    end
  end

  // Each lane is written only when its own read returns. Lanes not yet
  // refreshed keep the previous beat until the FETCH reaches them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (r_rd_vld) begin
      r_data[int'(r_rd_lane) * DATA_WIDTH +: DATA_WIDTH] <= r_rd_oob ? '0 : r_rd_word;
    end
  end

  assign matrix_data  = r_data;
  // The state encoding is one-hot, so this output is a single state flop.
  assign matrix_ready = (r_state == S_DONE);
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_matrix_loader.sv
module tb_matrix_loader;

  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int BW    = 16;
  localparam int DEPTH = 4096;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_write_enable;
  logic [AW-1:0]   mem_write_addr;
  logic [DW-1:0]   mem_write_data;
  logic [AW-1:0]   matrix_addr;
  logic            matrix_enable;
  logic [DW*BW-1:0] matrix_data;
  logic            matrix_ready;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]    exp_mem [DEPTH];
  logic [DW*BW-1:0] saved_beat;
  logic [DW*BW-1:0] exp_beat;
  int               lat;
  int               cyc;
  int               pulses;

  matrix_loader dut (
    .clk              (clk),
    .rst              (rst),
    .mem_write_enable (mem_write_enable),
    .mem_write_addr   (mem_write_addr),
    .mem_write_data   (mem_write_data),
    .matrix_addr      (matrix_addr),
    .matrix_enable    (matrix_enable),
    .matrix_data      (matrix_data),
    .matrix_ready     (matrix_ready),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW*BW-1:0] obs, input logic [DW*BW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected beat from the bench's own copy of the memory contents.
  function automatic logic [DW*BW-1:0] mk_beat(input int base);
    logic [DW*BW-1:0] b;
    b = '0;
    for (int i = 0; i < BW; i++) begin
      if (base + i < DEPTH) b[i*DW +: DW] = exp_mem[base + i];
    end
    return b;
  endfunction

  // Raise enable with the given base, then scramble matrix_addr (it must be
  // ignored once the fetch is running). Returns cycles from the sampling edge
  // to the first cycle where matrix_ready is seen high.
  task automatic do_fetch(input logic [AW-1:0] base, output int latency);
    int c;
    matrix_addr   = base;
    matrix_enable = 1'b1;
    tick();
    matrix_addr = ~base;
    c = 0;
    while (matrix_ready !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    latency = c;
  endtask

  initial begin
    rst              = 1'b1;
    mem_write_enable = 1'b0;
    mem_write_addr   = '0;
    mem_write_data   = '0;
    matrix_addr      = '0;
    matrix_enable    = 1'b0;
    tick();
    tick();
    chk("reset_busy",  busy,         0);
    chk("reset_ready", matrix_ready, 0);
    chk("reset_data",  matrix_data,  0);
    rst = 1'b0;

    // Load mem[k] = k+1
    for (int k = 0; k < DEPTH; k++) begin
      mem_write_enable = 1'b1;
      mem_write_addr   = AW'(k);
      mem_write_data   = DW'(k + 1);
      exp_mem[k]       = DW'(k + 1);
      tick();
    end
    mem_write_enable = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Base 0, enable held through ready
    do_fetch(12'd0, lat);
    chk("lat_base0",  lat,         17);
    chk("beat_base0", matrix_data, mk_beat(0));
    chk("busy_fetch", busy,        1);
    tick();
    chk("single_pulse", matrix_ready, 0);
    chk("hold_busy",    busy,         1);
    matrix_enable = 1'b0;
    tick();
    chk("busy_after_drop", busy, 0);

    // Base 4088 runs past the end: upper lanes read as zero
    exp_beat = '0;
    for (int i = 0; i < 8; i++) exp_beat[i*DW +: DW] = DW'(4089 + i);
    do_fetch(12'd4088, lat);
    chk("lat_base4088",  lat,         17);
    chk("beat_base4088", matrix_data, exp_beat);
    saved_beat = matrix_data;

    // Enable held 5 cycles after ready: no refetch
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (matrix_ready === 1'b1) pulses++;
    end
    chk("hold_no_refetch", pulses, 0);
    chk("hold_busy5",      busy,   1);
    matrix_enable = 1'b0;
    tick();
    chk("hold_exit_busy", busy,        0);
    chk("data_stable",    matrix_data, saved_beat);

    // Re-raise with base 16
    do_fetch(12'd16, lat);
    chk("lat_base16",  lat,         17);
    chk("beat_base16", matrix_data, mk_beat(16));
    matrix_enable = 1'b0;
    tick();

    // Write word 5 in the very cycle the fetch reads it: read-first
    matrix_addr   = 12'd0;
    matrix_enable = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    mem_write_enable = 1'b1;
    mem_write_addr   = 12'd5;
    mem_write_data   = 16'hBEEF;
    tick();
    mem_write_enable = 1'b0;
    cyc = 6;
    while (matrix_ready !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("lat_collide", cyc, 17);
    exp_beat = mk_beat(0);
    chk("lane5_old", matrix_data[5*DW +: DW], 16'd6);
    chk("beat_collide", matrix_data, exp_beat);
    exp_mem[5] = 16'hBEEF;
    matrix_enable = 1'b0;
    tick();
    do_fetch(12'd0, lat);
    chk("lat_refetch",  lat,                      17);
    chk("lane5_new",    matrix_data[5*DW +: DW], 16'hBEEF);
    chk("beat_refetch", matrix_data,              mk_beat(0));
    matrix_enable = 1'b0;
    tick();

    // Reset in the middle of a fetch
    matrix_addr   = 12'd0;
    matrix_enable = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    rst           = 1'b1;
    matrix_enable = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_data",  matrix_data,  0);
    chk("midrst_busy",  busy,         0);
    chk("midrst_ready", matrix_ready, 0);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (matrix_ready === 1'b1) pulses++;
    end
    chk("aborted_no_ready", pulses, 0);

    do_fetch(12'd32, lat);
    chk("lat_base32",  lat,         17);
    chk("beat_base32", matrix_data, mk_beat(32));
    // Enable low during the ready cycle: straight back to idle
    matrix_enable = 1'b0;
    tick();
    chk("done_to_idle_busy",  busy,         0);
    chk("done_to_idle_ready", matrix_ready, 0);
    chk("beat_base32_kept",   matrix_data,  mk_beat(32));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
